// File: rtl/cmp_guess_search_pkg.sv
// Shared types and flag decode for the comparator-driven binary search.
// CMP_FLAG_CHECK_EN enables strict decode of the three comparator flags.
package cmp_guess_pkg;

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, EVAL, DONE, ERR} state_e;
  typedef enum logic [1:0] {EQ, LT, GT, BAD} flag_res_e;

  function automatic flag_res_e decode_flags(input logic le, input logic ne, input logic ge);
    flag_res_e r;
`ifdef CMP_FLAG_CHECK_EN
    if (le & ge & ~ne)       r = EQ;
    else if (le & ~ge & ne)  r = LT;
    else if (ge & ~le & ne)  r = GT;
    else                     r = BAD;
`else
    // ne is not trusted here; "neither" falls to GT so the search narrows downward
    if (le & ge)   r = EQ;
    else if (le)   r = LT;
    else           r = GT;
    r = (ne & 1'b0) ? BAD : r;
`endif
    return r;
  endfunction

endpackage

// File: rtl/cmp_guess_search_if.sv
// Comparator bus: operand "a" out to the comparator, three flags back.
interface cmp_guess_search_if #(parameter int W = 4);
  logic [W-1:0] guess;
  logic         guess_valid;
  logic         cmp_le;
  logic         cmp_ne;
  logic         cmp_ge;

  modport master (output guess, guess_valid, input cmp_le, cmp_ne, cmp_ge);
  modport slave  (input guess, guess_valid, output cmp_le, cmp_ne, cmp_ge);
endinterface

// File: rtl/cmp_guess_search_flag_decode.sv
// Combinational decode of registered comparator flags (CMP_FLAG_CHECK_EN aware).
module cmp_flag_decode
  import cmp_guess_pkg::*;
(
  input  logic      le_i,
  input  logic      ne_i,
  input  logic      ge_i,
  output flag_res_e res_o
);
  assign res_o = decode_flags(le_i, ne_i, ge_i);
endmodule

// File: rtl/cmp_guess_search.sv
// Binary search of a comparator's hidden operand by driving successive guesses.
// Optional CMP_FLAG_CHECK_EN: inconsistent flag combinations abort with err.
module cmp_guess_search
  import cmp_guess_pkg::*;
#(
  parameter int W       = 4,
  parameter int CMP_LAT = 1,
  localparam int SW     = $clog2(W+2),
  localparam int CW     = $clog2(CMP_LAT+1)
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  cmp_guess_search_if.master  cmp,
  output logic                busy,
  output logic                done,
  output logic [W-1:0]        found,
  output logic [SW-1:0]       steps,
  output logic                err
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_DRIVE = DRIVE;
  localparam logic [2:0] S_WAIT  = WAIT;
  localparam logic [2:0] S_EVAL  = EVAL;
  localparam logic [2:0] S_DONE  = DONE;
  localparam logic [2:0] S_ERR   = ERR;

  logic [2:0]    state_q, state_d;
  logic [W-1:0]  lo_q, lo_d, hi_q, hi_d, guess_q, guess_d, found_q, found_d;
  logic          gv_q, gv_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [SW-1:0] steps_q, steps_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    flags_q, flags_d;
  logic [W:0]    sum;
  logic          last;
  flag_res_e     res;

  cmp_flag_decode u_dec (
    .le_i  (flags_q[2]),
    .ne_i  (flags_q[1]),
    .ge_i  (flags_q[0]),
    .res_o (res)
  );

  assign sum  = {1'b0, lo_q} + {1'b0, hi_q};
  // this EVAL is the (W+1)th comparison; anything but EQ is a failure
  assign last = (steps_q == SW'(W));

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    guess_d = guess_q;
    found_d = found_q;
    gv_d    = gv_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    steps_d = steps_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          lo_d    = '0;
          hi_d    = '1;
          steps_d = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        guess_d = sum[W:1];
        gv_d    = 1'b1;
        cnt_d   = CW'(CMP_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          flags_d = {cmp.cmp_le, cmp.cmp_ne, cmp.cmp_ge};
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        steps_d = steps_q + 1'b1;
        gv_d    = 1'b0;
        state_d = S_ERR;
        case (res)
          EQ: begin
            found_d = guess_q;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
          LT: if (guess_q != hi_q && !last) begin
            lo_d    = guess_q + 1'b1;
            state_d = S_DRIVE;
          end
          GT: if (guess_q != lo_q && !last) begin
            hi_d    = guess_q - 1'b1;
            state_d = S_DRIVE;
          end
          default: ;
        endcase
        if (state_d == S_ERR) err_d = 1'b1;
        if (state_d != S_DRIVE) busy_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lo_q    <= '0;
      hi_q    <= '1;
      guess_q <= '0;
      found_q <= '0;
      gv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      steps_q <= '0;
      cnt_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      guess_q <= guess_d;
      found_q <= found_d;
      gv_q    <= gv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      steps_q <= steps_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
    end
  end

  assign cmp.guess       = guess_q;
  assign cmp.guess_valid = gv_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign found           = found_q;
  assign steps           = steps_q;
  assign err             = err_q;

endmodule

// File: tb/tb_cmp_guess_search.sv
// Scoreboard bench: W=2/CMP_LAT=1 and W=4/CMP_LAT=3 searchers against modelled comparators.
module tb_cmp_guess_search;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start2 = 1'b0, start4 = 1'b0;
  always #5 clk = ~clk;

  cmp_guess_search_if #(.W(2)) if2 ();
  cmp_guess_search_if #(.W(4)) if4 ();

  logic       busy2, done2, err2, busy4, done4, err4;
  logic [1:0] found2, steps2;
  logic [3:0] found4;
  logic [2:0] steps4;

  cmp_guess_search #(.W(2), .CMP_LAT(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .cmp(if2),
    .busy(busy2), .done(done2), .found(found2), .steps(steps2), .err(err2));

  cmp_guess_search #(.W(4), .CMP_LAT(3)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .cmp(if4),
    .busy(busy4), .done(done4), .found(found4), .steps(steps4), .err(err4));

  int n_vec = 0, n_err = 0;
  int exp2[$], exp4[$];
  int g4_cnt = 0;
  int mode2 = 0;
  logic [1:0] sec2 = '0;
  logic [3:0] sec4 = '0;
  logic gv2_p = 1'b0, gv4_p = 1'b0;

  function automatic logic [2:0] cmpf(input logic [3:0] g, input logic [3:0] s);
    return {g <= s, g != s, g >= s};
  endfunction

  // W=2 comparator: ideal, all-flags-high, or stuck reporting guess < secret
  logic [2:0] f2;
  always_comb begin
    f2 = cmpf({2'b0, if2.guess}, {2'b0, sec2});
    if (mode2 == 1) f2 = 3'b111;
    else if (mode2 == 2) f2 = 3'b110;
  end
  assign if2.cmp_le = f2[2];
  assign if2.cmp_ne = f2[1];
  assign if2.cmp_ge = f2[0];

  // W=4 comparator with two register stages: flags are only right 3 edges after a guess change
  logic [2:0] f4_pipe [0:1];
  always @(posedge clk) begin
    f4_pipe[0] <= cmpf(if4.guess, sec4);
    f4_pipe[1] <= f4_pipe[0];
  end
  assign if4.cmp_le = f4_pipe[1][2];
  assign if4.cmp_ne = f4_pipe[1][1];
  assign if4.cmp_ge = f4_pipe[1][0];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    gv2_p <= if2.guess_valid;
    gv4_p <= if4.guess_valid;
    if (if2.guess_valid && !gv2_p) begin
      if (exp2.size() == 0) chk("g2_extra", {30'b0, if2.guess}, 32'hffff);
      else                  chk("g2_guess", {30'b0, if2.guess}, exp2.pop_front());
    end
    if (if4.guess_valid && !gv4_p) begin
      g4_cnt <= g4_cnt + 1;
      if (exp4.size() == 0) chk("g4_extra", {28'b0, if4.guess}, 32'hffff);
      else                  chk("g4_guess", {28'b0, if4.guess}, exp4.pop_front());
    end
  end

  // reference search for an ideal comparator: pushes the expected guess sequence
  task automatic push4(input int s);
    int lo = 0, hi = 15, g;
    for (int i = 0; i < 8; i++) begin
      g = (lo + hi) / 2;
      exp4.push_back(g);
      if (g == s) break;
      if (g < s) lo = g + 1; else hi = g - 1;
    end
  endtask

  task automatic run2(input logic [1:0] s, input int mode, input int ef, input int es,
                      input int ed, input int ee, input bit poke);
    sec2 = s; mode2 = mode;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    chk("busy2_go", busy2, 1);
    if (poke) begin
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
    end
    for (int c = 0; c < 100 && !(done2 || err2); c++) @(negedge clk);
    #1;
    chk("done2", done2, ed);
    chk("err2", err2, ee);
    chk("busy2_end", busy2, 0);
    chk("steps2", steps2, es);
    if (ed != 0) chk("found2", found2, ef);
    chk("q2_empty", exp2.size(), 0);
  endtask

  task automatic run4(input int s, input int es);
    sec4 = 4'(s);
    push4(s);
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    for (int c = 0; c < 200 && !(done4 || err4); c++) @(negedge clk);
    #1;
    chk("done4", done4, 1);
    chk("err4", err4, 0);
    chk("found4", found4, s);
    chk("steps4", steps4, es);
    chk("q4_empty", exp4.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_guess", if2.guess, 0);
    chk("rst_gv", if2.guess_valid, 0);
    chk("rst_outs", {busy2, done2, err2, found2, steps2}, 0);
    rst_n = 1'b1;

    exp2.push_back(1); exp2.push_back(2);
    run2(2'd2, 0, 2, 2, 1, 0, 1'b0);
    exp2.push_back(1); exp2.push_back(0);
    run2(2'd0, 0, 0, 2, 1, 0, 1'b0);
    exp2.push_back(1); exp2.push_back(2); exp2.push_back(3);
    run2(2'd3, 0, 3, 3, 1, 0, 1'b1);

    exp2.push_back(1);
`ifdef CMP_FLAG_CHECK_EN
    run2(2'd2, 1, 0, 1, 0, 1, 1'b0);
`else
    run2(2'd2, 1, 1, 1, 1, 0, 1'b0);
`endif
    exp2.push_back(1); exp2.push_back(2);
    run2(2'd2, 0, 2, 2, 1, 0, 1'b0);

    exp2.push_back(1); exp2.push_back(2); exp2.push_back(3);
    run2(2'd1, 2, 0, 3, 0, 1, 1'b0);

    run4(15, 5);
    run4(0, 4);
    run4(5, 3);
    run4(8, 4);

    // reset while the second guess is waiting on the comparator
    sec4 = 4'd15;
    push4(15);
    g4_cnt = 0;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    for (int c = 0; c < 100 && g4_cnt < 2; c++) begin
      @(negedge clk); #1;
    end
    chk("mid_gv", if4.guess_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_guess", if4.guess, 0);
    chk("mid_rst_gv", if4.guess_valid, 0);
    chk("mid_rst_outs", {busy4, done4, err4, found4, steps4}, 0);
    exp4.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_quiet", {busy4, done4, err4}, 0);
    run4(15, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cmp_guess_search.md
Name: cmp_guess_search

Overview:
- Sequential initiator for the team's 2-input magnitude comparator (outputs: a<=b, a!=b, a>=b).
- Drives the comparator's "a" operand with successive guesses and reads back the three flags.
- Binary-searches the hidden "b" operand and reports it.
- Sits between a start strobe (button/debounce) and comparator instances on the board; W generalises the existing 2-bit compare.

Parameters:
- W, 4, operand width in bits (W >= 2).
- CMP_LAT, 1, clock edges between a guess update and flag sampling (>= 1; 1 = purely combinational comparator).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a search.
- guess  output  W  operand driven to comparator input "a".
- guess_valid  output  1  high while guess is being compared.
- cmp_le  input  1  comparator flag, guess <= secret.
- cmp_ne  input  1  comparator flag, guess != secret.
- cmp_ge  input  1  comparator flag, guess >= secret.
- busy  output  1  search in progress.
- done  output  1  search finished successfully; held until next start.
- found  output  W  recovered secret; valid while done.
- steps  output  $clog2(W+2)  comparisons used, including the final equal one.
- err  output  1  search aborted on an impossible or inconsistent result; held until next start.

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0: guess, guess_valid, busy, done, found, steps, err. Internal lo=0, hi=2^W-1.
- Clock and reset are the only timing sources. Flags are treated as synchronous to clk.
- Flag decode:
  - EQ = le & ge & ~ne.
  - LT (guess < secret) = le & ~ge & ne.
  - GT = ge & ~le & ne.
  - Any other combination = BAD.
- States:
  - IDLE / DONE / ERR: on start, set lo=0, hi=2^W-1, steps=0, clear done and err, set busy=1, go to DRIVE. Without start, hold all outputs.
  - DRIVE (1 cycle): guess <= (lo+hi)>>1, with the sum computed at W+1 bits (no overflow). Set guess_valid=1, wait counter = CMP_LAT, go to WAIT.
  - WAIT: decrement the counter each cycle. On the edge where it reaches 0, register the flags and go to EVAL. The flags are therefore sampled exactly CMP_LAT edges after the edge that updated guess.
  - EVAL (1 cycle): steps++, guess_valid=0.
    - EQ: found <= guess, done=1, busy=0, go to DONE.
    - LT: if guess == hi, err=1, go to ERR; else lo <= guess+1, go to DRIVE.
    - GT: if guess == lo, err=1, go to ERR; else hi <= guess-1, go to DRIVE.
    - BAD: handled as in Optional Feature.
  - Entering ERR clears busy.
- Guarantees: a consistent comparator always terminates in at most W+1 comparisons. A search that reaches its (W+1)th EVAL without EQ sets err.
- start while busy is ignored.
- A start on the same cycle as the transition into DONE is ignored; start is sampled only while in the IDLE, DONE, or ERR state.
- Edge values: secret=0 and secret=2^W-1 must both be found without lo/hi under/overflow. guess-1 and guess+1 are never applied when they would wrap.
- Reset mid-search: immediate return to reset values. No done or err pulse is produced.

Optional Feature:
- Macro: CMP_FLAG_CHECK_EN.
- Defined: BAD flag combinations (e.g. le=ge=ne=1, or all zero) set err and go to ERR.
- Undefined: cmp_ne is ignored.
  - le & ge → EQ.
  - le only → LT.
  - ge only → GT.
  - neither → treated as GT.
  - BAD never occurs, and err is set only by the range checks and the step limit.

Decomposition:
- Package cmp_guess_pkg holds:
  - state enum {IDLE, DRIVE, WAIT, EVAL, DONE, ERR};
  - flag-result enum {EQ, LT, GT, BAD};
  - function decode_flags(le, ne, ge), returning the flag-result enum.
- One natural sub-module: cmp_flag_decode (combinational decode, macro-aware). It is shared with the bench's comparator model check.

Test Plan:
- W=2, CMP_LAT=1, secret=2 with the comparator modelled: guesses 1, then 2 → found=2, steps=2, done=1, err=0.
- W=2, secret=0 → guesses 1, then 0; found=0, steps=2. Secret=3 → guesses 1, 2, 3; found=3, steps=3.
- W=4, CMP_LAT=3, secret=15 → guesses 7, 11, 13, 14, 15; steps=5. Each flag sample occurs exactly 3 edges after guess changes.
- CMP_FLAG_CHECK_EN defined, flags forced le=1 ne=1 ge=1 on the first compare → err=1, done=0, busy=0, steps=1. Then start with a good comparator → normal search, err cleared.
- Range check: force LT on every compare (stuck comparator), W=2 → guesses 1, 2, 3, then err=1 with steps=3.
- Reset asserted during WAIT of the second guess → all outputs 0 asynchronously. A start after release gives a clean full search. start pulsed while busy → no restart, steps unaffected.
